mem_lsu: RTL and testbench

Multi-cycle load/store unit for the MEM stage, replacing single-cycle memory access with a request/acknowledge bus handshake, wait states, alignment checking and a bus-timeout error. It sits between the EX/MEM pipeline register and the data-bus arbiter. It receives an already-translated physical address plus the MMU hit flag. While an access is outstanding it stalls the pipeline, then hands the extended load data and the exception code to the write-back path.

---
 rtl/mem_lsu_pkg.sv | 55 +++++
 rtl/lsu_lane_align.sv | 51 +++++
 rtl/mem_lsu.sv | 176 +++++++++++++++++
 tb/tb_mem_lsu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared AluOp codes, exception codes and op decode for the MEM-stage load/store unit.
package mem_lsu_pkg;

  typedef logic [7:0] aluop_t;

  localparam aluop_t EXE_LB_OP  = 8'b1110_0000;
  localparam aluop_t EXE_LH_OP  = 8'b1110_0001;
  localparam aluop_t EXE_LW_OP  = 8'b1110_0011;
  localparam aluop_t EXE_LBU_OP = 8'b1110_0100;
  localparam aluop_t EXE_LHU_OP = 8'b1110_0101;
  localparam aluop_t EXE_SB_OP  = 8'b1110_1000;
  localparam aluop_t EXE_SH_OP  = 8'b1110_1001;
  localparam aluop_t EXE_SW_OP  = 8'b1110_1011;

  localparam logic        RstEnable  = 1'b1;
  localparam logic        ChipEnable = 1'b1;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_TLBL = 32'h0000_000f;
  localparam logic [31:0] EXC_TLBS = 32'h0000_000b;
  localparam logic [31:0] EXC_DBE  = 32'h0000_0007;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic       vld;
    logic       load;
    logic       store;
    logic [1:0] size;
    logic       sext;
  } op_dec_t;

  function automatic op_dec_t decode_op(input aluop_t op);
    op_dec_t d;
    d = '0;
    case (op)
      EXE_LB_OP:  d = '{vld: 1'b1, load: 1'b1, store: 1'b0, size: SZ_B, sext: 1'b1};
      EXE_LBU_OP: d = '{vld: 1'b1, load: 1'b1, store: 1'b0, size: SZ_B, sext: 1'b0};
      EXE_LH_OP:  d = '{vld: 1'b1, load: 1'b1, store: 1'b0, size: SZ_H, sext: 1'b1};
      EXE_LHU_OP: d = '{vld: 1'b1, load: 1'b1, store: 1'b0, size: SZ_H, sext: 1'b0};
      EXE_LW_OP:  d = '{vld: 1'b1, load: 1'b1, store: 1'b0, size: SZ_W, sext: 1'b0};
      EXE_SB_OP:  d = '{vld: 1'b1, load: 1'b0, store: 1'b1, size: SZ_B, sext: 1'b0};
      EXE_SH_OP:  d = '{vld: 1'b1, load: 1'b0, store: 1'b1, size: SZ_H, sext: 1'b0};
      EXE_SW_OP:  d = '{vld: 1'b1, load: 1'b0, store: 1'b1, size: SZ_W, sext: 1'b0};
      default:    d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store lane select/replication, load lane extract/extend, misalignment.
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  aluop_t      op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  op_dec_t     dec;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign dec = decode_op(op_i);

  always_comb begin
    sel_o        = 4'b0000;
    wdata_o      = 32'h0;
    load_data_o  = 32'h0;
    misaligned_o = 1'b0;
    rbyte        = rdata_i[{addr_lo_i, 3'b000} +: 8];
    rhalf        = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    if (dec.vld) begin
      case (dec.size)
        SZ_B: begin
          sel_o   = 4'b0001 << addr_lo_i;
          wdata_o = {4{store_data_i[7:0]}};
          if (dec.load) load_data_o = {{24{dec.sext & rbyte[7]}}, rbyte};
        end
        SZ_H: begin
          sel_o        = 4'b0011 << addr_lo_i;
          wdata_o      = {2{store_data_i[15:0]}};
          misaligned_o = addr_lo_i[0];
          if (dec.load) load_data_o = {{16{dec.sext & rhalf[15]}}, rhalf};
        end
        default: begin
          sel_o        = 4'b1111;
          wdata_o      = store_data_i;
          misaligned_o = |addr_lo_i;
          if (dec.load) load_data_o = rdata_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack bus handshake with wait states, alignment/TLB
// checks and bus timeout; stalls the pipeline while an access is outstanding.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  aluop_t            aluop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              tlb_hit_i,
  input  logic [31:0]       store_data_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       load_data_o,
  output logic [31:0]       excepttype_o,
  output logic [ADDR_W-1:0] bad_address_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  aluop_t            op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              flush_pend_q, flush_pend_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [31:0]       exc_q, exc_d;
  logic [ADDR_W-1:0] bad_q, bad_d;

  op_dec_t     in_dec;
  logic        accept;
  aluop_t      al_op;
  logic [1:0]  al_lo;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_mis;

  assign in_dec = decode_op(aluop_i);
  assign accept = (state_q == ST_IDLE) & req_valid_i & ~flush_i & in_dec.vld;

  // In IDLE the aligner classifies the incoming op; afterwards it extracts load
  // data for the latched op.
  assign al_op = (state_q == ST_IDLE) ? aluop_i : op_q;
  assign al_lo = (state_q == ST_IDLE) ? addr_i[1:0] : addr_q[1:0];

  lsu_lane_align u_align (
    .op_i         (al_op),
    .addr_lo_i    (al_lo),
    .store_data_i (store_data_i),
    .rdata_i      (bus_rdata_i),
    .sel_o        (al_sel),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load),
    .misaligned_o (al_mis)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    flush_pend_d = flush_pend_q;
    load_data_d  = load_data_q;
    exc_d        = exc_q;
    bad_d        = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d         = aluop_i;
          addr_d       = addr_i;
          sel_d        = al_sel;
          wdata_d      = al_wdata;
          we_d         = in_dec.store;
          flush_pend_d = 1'b0;
          cnt_d        = '0;
          load_data_d  = ZeroWord;
          exc_d        = EXC_NONE;
          bad_d        = '0;
          // Misalignment outranks a TLB miss.
          if (al_mis) begin
            exc_d   = in_dec.load ? EXC_ADEL : EXC_ADES;
            bad_d   = addr_i;
            we_d    = 1'b0;
            state_d = ST_DONE;
          end else if (!tlb_hit_i) begin
            exc_d   = in_dec.load ? EXC_TLBL : EXC_TLBS;
            bad_d   = addr_i;
            we_d    = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (bus_ack_i) begin
          load_data_d = al_load;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            exc_d   = EXC_DBE;
            bad_d   = addr_q;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      sel_q        <= '0;
      wdata_q      <= ZeroWord;
      we_q         <= 1'b0;
      flush_pend_q <= 1'b0;
      load_data_q  <= ZeroWord;
      exc_q        <= EXC_NONE;
      bad_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      flush_pend_q <= flush_pend_d;
      load_data_q  <= load_data_d;
      exc_q        <= exc_d;
      bad_q        <= bad_d;
    end
  end

  assign stall_o       = accept | (state_q == ST_BUS);
  assign done_o        = (state_q == ST_DONE) & ~flush_pend_q & ~flush_i;
  assign bus_req_o     = (state_q == ST_BUS);
  assign bus_we_o      = bus_req_o & we_q;
  assign bus_addr_o    = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_sel_o     = sel_q;
  assign bus_wdata_o   = wdata_q;
  assign load_data_o   = load_data_q;
  assign excepttype_o  = exc_q;
  assign bad_address_o = bad_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a short bus timeout.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  aluop_t      aluop;
  logic [31:0] addr;
  logic        tlb_hit;
  logic [31:0] store_data;
  logic        flush;
  logic        stall, done;
  logic [31:0] load_data, exc, bad_addr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  mem_lsu #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .aluop_i(aluop), .addr_i(addr),
    .tlb_hit_i(tlb_hit), .store_data_i(store_data), .flush_i(flush),
    .stall_o(stall), .done_o(done), .load_data_o(load_data), .excepttype_o(exc),
    .bad_address_o(bad_addr), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_sel_o(bus_sel), .bus_wdata_o(bus_wdata),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  int          done_cyc, stall_cnt, req_cnt, done_cnt;
  logic        acc_stall, we_seen;
  logic [3:0]  sel_seen;
  logic [31:0] wdata_seen, addr_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one op in the current cycle and watches 12 following cycles.
  // ack_at / flush_at: cycle index after acceptance (0 = acceptance cycle for flush, -1 = never).
  task automatic run_op(input aluop_t op, input logic [31:0] a, input logic hit,
                        input logic [31:0] wd, input int ack_at, input int flush_at,
                        input logic [31:0] rd);
    req_valid = 1'b1; aluop = op; addr = a; tlb_hit = hit; store_data = wd;
    flush = (flush_at == 0);
    @(negedge clk);
    acc_stall = stall;
    done_cyc = -1; done_cnt = 0; stall_cnt = 0; req_cnt = 0;
    we_seen = 1'b0; sel_seen = '0; wdata_seen = '0; addr_seen = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush     = (c == flush_at);
      bus_ack   = (c == ack_at);
      bus_rdata = (c == ack_at) ? rd : 32'h0;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (bus_we) we_seen = 1'b1;
      if (bus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          sel_seen = bus_sel; wdata_seen = bus_wdata; addr_seen = bus_addr;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    @(posedge clk); #1;
    bus_ack = 1'b0; flush = 1'b0; bus_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; aluop = '0; addr = '0; tlb_hit = 1'b1;
    store_data = '0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", {31'b0, bus_req}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_exc", exc, 32'h0);
    chk("rst_load", load_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LB with 2 wait cycles, sign-extended top byte
    run_op(EXE_LB_OP, 32'h8000_0003, 1'b1, 32'h0, 3, -1, 32'h9A00_0000);
    chk("lb_acc_stall", {31'b0, acc_stall}, 32'h1);
    chk("lb_sel", {28'b0, sel_seen}, 32'h8);
    chk("lb_addr", addr_seen, 32'h8000_0000);
    chk("lb_load", load_data, 32'hFFFF_FF9A);
    chk("lb_done_cyc", done_cyc, 32'd4);
    chk("lb_stall_cnt", stall_cnt, 32'd3);
    chk("lb_exc", exc, 32'h0);

    // SH upper half, immediate ack
    run_op(EXE_SH_OP, 32'h0000_1002, 1'b1, 32'h1234_ABCD, 1, -1, 32'h0);
    chk("sh_sel", {28'b0, sel_seen}, 32'hC);
    chk("sh_wdata", wdata_seen, 32'hABCD_ABCD);
    chk("sh_we", {31'b0, we_seen}, 32'h1);
    chk("sh_exc", exc, 32'h0);
    chk("sh_done_cyc", done_cyc, 32'd2);
    chk("sh_load", load_data, 32'h0);

    // SB replicated data, lane 1
    run_op(EXE_SB_OP, 32'h0000_1001, 1'b1, 32'h0000_0077, 1, -1, 32'h0);
    chk("sb_sel", {28'b0, sel_seen}, 32'h2);
    chk("sb_wdata", wdata_seen, 32'h7777_7777);

    // Misaligned LW -> AdEL
    run_op(EXE_LW_OP, 32'h0000_1006, 1'b1, 32'h0, 1, -1, 32'h0);
    chk("lw_mis_req", req_cnt, 32'd0);
    chk("lw_mis_exc", exc, 32'h4);
    chk("lw_mis_bad", bad_addr, 32'h0000_1006);
    chk("lw_mis_done", done_cyc, 32'd1);

    // Misaligned SW with TLB miss -> AdES wins
    run_op(EXE_SW_OP, 32'h0000_1006, 1'b0, 32'h5555_5555, 1, -1, 32'h0);
    chk("sw_mis_exc", exc, 32'h5);
    chk("sw_mis_req", req_cnt, 32'd0);

    // TLB misses
    run_op(EXE_SW_OP, 32'h0000_2000, 1'b0, 32'h5555_5555, 1, -1, 32'h0);
    chk("sw_tlb_exc", exc, 32'h0b);
    chk("sw_tlb_we", {31'b0, we_seen}, 32'h0);
    chk("sw_tlb_req", req_cnt, 32'd0);
    chk("sw_tlb_bad", bad_addr, 32'h0000_2000);
    run_op(EXE_LHU_OP, 32'h0000_2002, 1'b0, 32'h0, 1, -1, 32'h0);
    chk("lhu_tlb_exc", exc, 32'h0f);
    chk("lhu_tlb_done", done_cyc, 32'd1);

    // Bus timeout
    run_op(EXE_LW_OP, 32'h0000_3000, 1'b1, 32'h0, -1, -1, 32'h0);
    chk("to_req_cnt", req_cnt, 32'd4);
    chk("to_exc", exc, 32'h7);
    chk("to_bad", bad_addr, 32'h0000_3000);
    chk("to_done_cyc", done_cyc, 32'd5);

    // Extension variants
    run_op(EXE_LH_OP, 32'h0000_4002, 1'b1, 32'h0, 1, -1, 32'h8001_1234);
    chk("lh_load", load_data, 32'hFFFF_8001);
    run_op(EXE_LBU_OP, 32'h0000_4001, 1'b1, 32'h0, 2, -1, 32'h0000_F000);
    chk("lbu_load", load_data, 32'h0000_00F0);
    run_op(EXE_LHU_OP, 32'h0000_4000, 1'b1, 32'h0, 1, -1, 32'h1234_FEDC);
    chk("lhu_load", load_data, 32'h0000_FEDC);
    run_op(EXE_LW_OP, 32'h0000_4004, 1'b1, 32'h0, 1, -1, 32'hDEAD_BEEF);
    chk("lw_load", load_data, 32'hDEAD_BEEF);

    // Flush during BUS: request held to ack, done suppressed
    run_op(EXE_LW_OP, 32'h0000_5000, 1'b1, 32'h0, 3, 1, 32'h1111_1111);
    chk("fl_bus_req", req_cnt, 32'd3);
    chk("fl_bus_done", done_cnt, 32'd0);

    // Flush in IDLE: not accepted
    run_op(EXE_LW_OP, 32'h0000_5004, 1'b1, 32'h0, 1, 0, 32'h0);
    chk("fl_idle_stall", {31'b0, acc_stall}, 32'h0);
    chk("fl_idle_req", req_cnt, 32'd0);
    chk("fl_idle_done", done_cnt, 32'd0);

    // Reset in the middle of a bus access
    req_valid = 1'b1; aluop = EXE_LW_OP; addr = 32'h0000_6000; tlb_hit = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mr_pre_req", {31'b0, bus_req}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_req", {31'b0, bus_req}, 32'h0);
    chk("mr_done", {31'b0, done}, 32'h0);
    chk("mr_stall", {31'b0, stall}, 32'h0);
    chk("mr_exc", exc, 32'h0);
    @(posedge clk); #1;
    run_op(EXE_LW_OP, 32'h0000_6004, 1'b1, 32'h0, 1, -1, 32'hCAFE_F00D);
    chk("mr_next_done", done_cyc, 32'd2);
    chk("mr_next_load", load_data, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
